// File: rtl/ivector_requester_pkg.sv
// ivector_requester_pkg: shared states, widths and the say/heard payload generator.
package ivector_requester_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam int SEQ_W_DEF = 16;
  localparam int PAD_W = 176;
  localparam int PAY_W = 192;
  localparam logic [15:0] PATTERN = 16'hA5A5;
  typedef struct packed {
    logic [PAY_W-1:0] meth;
    logic [PAY_W-1:0] v;
  } payload_t;
  function automatic payload_t payload(input logic [15:0] s);
    payload_t p;
    p.meth = {{PAD_W{1'b0}}, s};
    p.v = {12{s ^ PATTERN}};
    return p;
  endfunction
endpackage

// File: rtl/ivector_seq_fifo.sv
// ivector_seq_fifo: expected-sequence store; dout is a register always holding the current head.
module ivector_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, nrd;
  assign nrd = pop ? rd_ptr + AW'(1) : rd_ptr;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  // a push landing in the slot that becomes head must bypass the array
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      dout <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= nrd;
      count <= count + CW'(push) - CW'(pop);
      dout <= (push && wr_ptr == nrd) ? din : mem[nrd];
    end
endmodule

// File: rtl/ivector_requester.sv
// ivector_requester: issues numbered say requests and scores the returned heard indications.
module ivector_requester
  import ivector_requester_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SEQ_W = SEQ_W_DEF,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start__ENA,
  input  logic [SEQ_W-1:0] start_count,
  output logic             start__RDY,
  output logic             say__ENA,
  output logic [PAY_W-1:0] say_meth,
  output logic [PAY_W-1:0] say_v,
  input  logic             say__RDY,
  input  logic             heard__ENA,
  input  logic [PAY_W-1:0] heard_meth,
  input  logic [PAY_W-1:0] heard_v,
  output logic             heard__RDY,
  output logic             done,
  output logic [SEQ_W-1:0] match_count,
  output logic [SEQ_W-1:0] mismatch_count,
  output logic [CW-1:0]    outstanding
);
  state_t state, nxt;
  logic [SEQ_W-1:0] count, sent, seq, head;
  logic heard_go, ok;
  payload_t sp, hp;
  assign sp = payload(16'(seq));
  assign hp = payload(16'(head));
  assign say_meth = sp.meth;
  assign say_v = sp.v;
  assign heard_go = heard__ENA & heard__RDY;
  assign ok = heard_meth == hp.meth && heard_v == hp.v;
  always_comb begin
    nxt = state;
    start__RDY = state == IDLE || state == DONE;
    done = state == DONE;
    heard__RDY = outstanding != '0;
    say__ENA = state == ISSUE && sent < count && outstanding < CW'(DEPTH) && say__RDY;
    if (start__ENA && start__RDY) nxt = start_count == '0 ? DONE : ISSUE;
    else if (state == ISSUE && say__ENA && sent + SEQ_W'(1) == count) nxt = DRAIN;
    else if (state == DRAIN && outstanding == '0) nxt = DONE;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      count <= '0;
      sent <= '0;
      seq <= '0;
      match_count <= '0;
      mismatch_count <= '0;
    end else if (start__ENA && start__RDY) begin
      count <= start_count;
      sent <= '0;
      seq <= '0;
      match_count <= '0;
      mismatch_count <= '0;
    end else begin
      if (say__ENA) begin
        sent <= sent + SEQ_W'(1);
        seq <= seq + SEQ_W'(1);
      end
      if (heard_go && ok && !(&match_count)) match_count <= match_count + SEQ_W'(1);
      if (heard_go && !ok && !(&mismatch_count)) mismatch_count <= mismatch_count + SEQ_W'(1);
    end
  ivector_seq_fifo #(.DEPTH(DEPTH), .W(SEQ_W)) u_fifo (
    .clk(CLK),
    .rst(RST),
    .push(say__ENA),
    .pop(heard_go),
    .din(seq),
    .dout(head),
    .count(outstanding)
  );
endmodule

// File: tb/tb_ivector_requester.sv
// tb_ivector_requester: queue-based reference model checked every cycle, plus directed scenarios.
module tb_ivector_requester;
  localparam int DEPTH = 4;
  logic CLK = 0, RST = 1, start__ENA = 0, say__RDY = 1, heard__ENA = 0;
  logic [15:0] start_count = 0;
  logic [191:0] heard_meth = '0, heard_v = '0;
  logic start__RDY, say__ENA, heard__RDY, done;
  logic [191:0] say_meth, say_v;
  logic [15:0] match_count, mismatch_count;
  logic [2:0] outstanding;

  ivector_requester #(.DEPTH(DEPTH), .SEQ_W(16)) dut (
    .CLK(CLK), .RST(RST), .start__ENA(start__ENA), .start_count(start_count),
    .start__RDY(start__RDY), .say__ENA(say__ENA), .say_meth(say_meth), .say_v(say_v),
    .say__RDY(say__RDY), .heard__ENA(heard__ENA), .heard_meth(heard_meth), .heard_v(heard_v),
    .heard__RDY(heard__RDY), .done(done), .match_count(match_count),
    .mismatch_count(mismatch_count), .outstanding(outstanding)
  );

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [191:0] vpat(input logic [15:0] s);
    return {12{s ^ 16'hA5A5}};
  endfunction

  // reference model: phase 0 idle, 1 issuing, 2 draining, 3 done
  int m_phase = 0, cyc = 0, p_out = 0, co_hits = 0;
  int unsigned m_count = 0, m_sent = 0, m_match = 0, m_mis = 0;
  logic [15:0] m_seq = 0, p_cnt = 0;
  logic [15:0] mq[$];
  logic p_say = 0, p_heard = 0, p_start = 0, p_ok = 0;
  logic [15:0] rq_s[$], say_log[$];
  int rq_c[$], say_cyc[$];

  always @(negedge CLK) begin
    if (RST) begin
      m_phase = 0; mq.delete(); m_count = 0; m_sent = 0; m_seq = 0; m_match = 0; m_mis = 0;
    end
    p_out = mq.size();
    p_say = m_phase == 1 && m_sent < m_count && p_out < DEPTH && say__RDY;
    p_heard = heard__ENA && p_out > 0;
    p_start = start__ENA && (m_phase == 0 || m_phase == 3);
    p_ok = p_heard ? (heard_meth == {176'b0, mq[0]} && heard_v == vpat(mq[0])) : 1'b0;
    p_cnt = start_count;
    chk("say_ena", say__ENA, p_say);
    chk("start_rdy", start__RDY, m_phase == 0 || m_phase == 3);
    chk("heard_rdy", heard__RDY, p_out > 0);
    chk("done", done, m_phase == 3);
    chk("outstanding", outstanding, p_out);
    chk("match_count", match_count, m_match);
    chk("mismatch_count", mismatch_count, m_mis);
    if (p_say) begin
      chk("say_meth", say_meth, {176'b0, m_seq});
      chk("say_v", say_v, vpat(m_seq));
    end
    if (say__ENA && say__RDY) begin
      rq_s.push_back(say_meth[15:0]); rq_c.push_back(cyc);
      say_log.push_back(say_meth[15:0]); say_cyc.push_back(cyc);
    end
    if (p_say && p_heard && p_out == 2) co_hits++;
  end

  always @(posedge CLK) begin
    cyc++;
    if (!RST) begin
      if (p_heard) begin
        void'(mq.pop_front());
        if (p_ok) m_match = m_match == 65535 ? m_match : m_match + 1;
        else m_mis = m_mis == 65535 ? m_mis : m_mis + 1;
      end
      if (p_say) begin
        mq.push_back(m_seq); m_sent++; m_seq++;
      end
      if (p_start) begin
        m_count = p_cnt; m_sent = 0; m_seq = 0; m_match = 0; m_mis = 0;
        m_phase = p_cnt == 0 ? 3 : 1;
      end else if (m_phase == 1 && p_say && m_sent == m_count) m_phase = 2;
      else if (m_phase == 2 && p_out == 0) m_phase = 3;
    end
  end

  // loopback responder: echoes each say after lat cycles, optionally corrupting one
  int lat = 2, n_resp = 0, corrupt_n = 0;
  bit echo_en = 0, force_heard = 0;
  always @(posedge CLK) begin
    logic [15:0] s;
    #1;
    heard__ENA = force_heard; heard_meth = '0; heard_v = '0;
    if (echo_en && rq_s.size() > 0 && cyc >= rq_c[0] + lat) begin
      s = rq_s.pop_front(); void'(rq_c.pop_front());
      n_resp++;
      heard__ENA = 1; heard_meth = {176'b0, s}; heard_v = vpat(s);
      if (n_resp == corrupt_n) heard_v[0] = ~heard_v[0];
    end
  end

  task automatic start_run(input logic [15:0] n);
    say_log.delete(); say_cyc.delete();
    @(posedge CLK); #1 start__ENA = 1; start_count = n;
    @(posedge CLK); #1 start__ENA = 0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 300) begin
      @(posedge CLK); #1; k++;
    end
    chk(name, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge CLK); #1;
    chk("rst_start_rdy", start__RDY, 1);
    chk("rst_say_ena", say__ENA, 0);
    chk("rst_heard_rdy", heard__RDY, 0);
    chk("rst_done", done, 0);
    @(posedge CLK); #1 RST = 0;
    // three-request loopback
    echo_en = 1; lat = 2;
    start_run(3);
    wait_done("r1_done");
    chk("r1_match", match_count, 3);
    chk("r1_mismatch", mismatch_count, 0);
    chk("r1_n_says", say_log.size(), 3);
    for (int i = 0; i < 3 && i < say_log.size(); i++) begin
      chk("r1_seq", say_log[i], i);
      if (i > 0) chk("r1_consecutive", say_cyc[i], say_cyc[i-1] + 1);
    end
    // stall at full with no responses, then release
    echo_en = 0;
    start_run(10);
    repeat (12) @(posedge CLK); #1;
    chk("r2_outstanding_full", outstanding, 4);
    chk("r2_stalled_says", say_log.size(), 4);
    chk("r2_busy", start__RDY, 0);
    chk("r2_not_done", done, 0);
    echo_en = 1;
    wait_done("r2_done");
    chk("r2_n_says", say_log.size(), 10);
    chk("r2_match", match_count, 10);
    // corrupt second indication
    corrupt_n = n_resp + 2;
    start_run(4);
    wait_done("r3_done");
    chk("r3_match", match_count, 3);
    chk("r3_mismatch", mismatch_count, 1);
    // concurrent say and heard at outstanding 2
    corrupt_n = 0; co_hits = 0;
    start_run(6);
    wait_done("r4_done");
    chk("r4_cohit_seen", co_hits > 0, 1);
    chk("r4_match", match_count, 6);
    chk("r4_mismatch", mismatch_count, 0);
    // heard while not ready is ignored; zero-count run
    force_heard = 1;
    repeat (3) @(posedge CLK); #1;
    chk("r5_ignored_match", match_count, 6);
    chk("r5_ignored_mis", mismatch_count, 0);
    start_run(0);
    chk("r5_done_next", done, 1);
    chk("r5_no_says", say_log.size(), 0);
    chk("r5_match_zero", match_count, 0);
    chk("r5_mis_zero", mismatch_count, 0);
    force_heard = 0;
    // reset mid-run
    echo_en = 0;
    start_run(5);
    for (int k = 0; k < 20 && outstanding != 3; k++) begin
      @(posedge CLK); #1;
    end
    chk("r6_out3_reached", outstanding, 3);
    RST = 1; #1;
    chk("r6_rst_say_ena", say__ENA, 0);
    chk("r6_rst_heard_rdy", heard__RDY, 0);
    chk("r6_rst_done", done, 0);
    chk("r6_rst_start_rdy", start__RDY, 1);
    chk("r6_rst_outstanding", outstanding, 0);
    @(posedge CLK); #1 RST = 0;
    rq_s.delete(); rq_c.delete();
    echo_en = 1;
    start_run(2);
    wait_done("r6_done");
    chk("r6_match", match_count, 2);
    chk("r6_n_says", say_log.size(), 2);
    if (say_log.size() == 2) begin
      chk("r6_seq0", say_log[0], 0);
      chk("r6_seq1", say_log[1], 1);
    end
    repeat (2) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
